// File: rtl/settle_seq_pkg.sv
// settle_seq_pkg
//   Shared types and defaults for the settle sequencer slice.
//   - state_e    : controller state encoding (IDLE / SETTLE / RESP)
//   - req_id_t   : requester index (two requesters -> 1 bit)
//   - rsp_t      : registered response payload (sampled data + owner id)
//   - *_W_DEF    : default operand and settle-counter widths
package settle_seq_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 4;
  localparam int ID_W       = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    data;
    req_id_t id;
  } rsp_t;

endpackage

// File: rtl/settle_sequencer_if.sv
// settle_sequencer_if
//   Bundles the two requester handshakes, the response handshake and the
//   drive/sense pins of the shared delay network.
//   slave  : the sequencer's view (accepts requests, drives net_in, returns rsp)
//   master : the requester/consumer/network side
//   req{0,1}_valid/data/ready : operand handshake per requester
//   net_in / net_out          : network drive {a,b,c,d} and its output
//   rsp_valid/ready/data/id   : result handshake
interface settle_sequencer_if
  import settle_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [DATA_W-1:0] net_in;
  logic              net_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_data;
  logic              rsp_id;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, net_out, rsp_ready,
    output req0_ready, req1_ready, net_in, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, net_out, rsp_ready,
    input  req0_ready, req1_ready, net_in, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
//   Two-requester round-robin grant, purely combinational.
//   valid   : request bits {req1, req0}
//   ptr     : requester that wins when both are valid
//   en      : grant only while enabled (controller idle)
//   gnt     : one-hot grant, all-zero when disabled or nothing valid
//   gnt_idx : index of the selected requester (meaningful when |gnt)
module rr_arbiter_2
  import settle_seq_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output req_id_t    gnt_idx
);

  always_comb begin
    // A lone requester wins regardless of the pointer; contention goes to ptr.
    gnt_idx = (valid == 2'b11) ? ptr : valid[1];
    gnt     = '0;
    if (en && |valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/settle_sequencer.sv
// settle_sequencer
//   Shares one combinational AND network between two requesters. A winning
//   operand is registered onto net_in, the controller waits eff_settle cycles
//   for the network to settle, samples net_out and returns it with its owner.
//   clock, reset_n : rising-edge clock, async active-low reset
//   settle_cycles  : settle wait in cycles, captured at accept (0 acts as 1)
//   busy           : high whenever a transaction is in flight or unconsumed
//   bus            : requester / response / network signals (slave view)
module settle_sequencer
  import settle_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] settle_cycles,
  output logic             busy,
  settle_sequencer_if.slave bus
);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] net_in_q;
  logic              rsp_valid_q;
  rsp_t              rsp_q;
  req_id_t           rr_ptr;

  logic [1:0]        req_vld;
  logic [1:0]        gnt;
  req_id_t           gnt_idx;
  logic [CNT_W-1:0]  eff_settle;
  logic [DATA_W-1:0] gnt_data;

  assign req_vld = {bus.req1_valid, bus.req0_valid};

  rr_arbiter_2 u_arb (
    .valid   (req_vld),
    .ptr     (rr_ptr),
    .en      (state == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  // A zero load would make the counter wrap; clamp to one cycle instead.
  assign eff_settle = (settle_cycles == '0) ? CNT_W'(1) : settle_cycles;
  assign gnt_data   = gnt_idx[0] ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      net_in_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            net_in_q <= gnt_data;
            rsp_q.id <= gnt_idx;
            cnt      <= eff_settle;
            rr_ptr   <= ~gnt_idx;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - CNT_W'(1);
          // cnt==1 marks the S-th edge after accept: net_in has been stable
          // for S full cycles when net_out is captured here.
          if (cnt == CNT_W'(1)) begin
            rsp_q.data  <= bus.net_out;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          // Return to IDLE only; the next accept is on the following edge.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // net_in is only rewritten on accept, so it holds through RESP and IDLE.
  assign bus.net_in    = net_in_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_q.data;
  assign bus.rsp_id    = rsp_q.id[0];
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_settle_sequencer.sv
// tb_settle_sequencer
//   Drives the settle sequencer against a behavioural 4-input AND network
//   (two 5-unit first-level gates, 6-unit second level, worst path 11).
//   Expected results go to a scoreboard queue at accept and are compared
//   when the response handshake completes.
`timescale 1ns/100ps
module tb_settle_sequencer;
  import settle_seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] settle_cycles = 4'd2;
  logic       busy;
  realtime    half = 5.0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         exp_ptr = 0;

  typedef struct {
    logic id;
    logic data;
  } exp_t;
  exp_t sb[$];

  settle_sequencer_if #(.DATA_W(4)) bus();

  settle_sequencer #(.CNT_W(4), .DATA_W(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .settle_cycles (settle_cycles),
    .busy          (busy),
    .bus           (bus)
  );

  logic ab, cd;
  assign #5 ab          = bus.net_in[3] & bus.net_in[2];
  assign #5 cd          = bus.net_in[1] & bus.net_in[0];
  assign #6 bus.net_out = ab & cd;

  always #(half) clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Waits for a ready, records the accept edge number and the winner.
  task automatic wait_accept(output int acc, output int who);
    who = -1;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.req0_ready || bus.req1_ready) begin
        who = bus.req1_ready ? 1 : 0;
        acc = cyc + 1;
        break;
      end
    end
    if (who >= 0) begin
      exp_ptr = 1 - who;
      @(posedge clock); #1;
    end
  endtask

  // Waits for rsp_valid, captures it, then completes the handshake.
  task automatic get_rsp(input int acc, output int lat, output logic d, output logic id);
    lat = -1;
    d   = 1'bx;
    id  = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) begin
        lat = cyc - acc;
        d   = bus.rsp_data;
        id  = bus.rsp_id;
        break;
      end
    end
    if (lat >= 0) begin
      bus.rsp_ready = 1'b1;
      @(posedge clock); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.net_in !== 4'b0000) begin errors++; $display("FAIL reset_net_in got %b want 0000", bus.net_in); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if ({bus.rsp_data, bus.rsp_id} !== 2'b00) begin errors++; $display("FAIL reset_rsp got %b%b want 00", bus.rsp_data, bus.rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset_n = 1'b1;
    exp_ptr = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    int acc, who, lat;
    logic d, id;
    exp_t e;
    settle_cycles = 4'd2;
    bus.req0_data = 4'b1111;
    bus.req0_valid = 1'b1;
    wait_accept(acc, who);
    bus.req0_valid = 1'b0;
    checks++; if (who !== 0) begin errors++; $display("FAIL single_grant got %0d want 0", who); end
    sb.push_back('{id: 1'b0, data: 1'b1});
    @(negedge clock);
    checks++; if (bus.net_in !== 4'b1111) begin errors++; $display("FAIL single_net_in got %b want 1111", bus.net_in); end
    get_rsp(acc, lat, d, id);
    e = sb.pop_front();
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", lat); end
    checks++; if (d !== e.data || id !== e.id) begin errors++; $display("FAIL single_rsp got d=%b id=%b want d=%b id=%b", d, id, e.data, e.id); end
  endtask

  task automatic test_alternate();
    int acc, prev_acc, who, lat, want;
    logic d, id;
    exp_t e;
    settle_cycles = 4'd2;
    bus.req0_data = 4'b0111;
    bus.req1_data = 4'b1111;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    prev_acc = -1;
    for (int n = 0; n < 4; n++) begin
      want = exp_ptr;
      wait_accept(acc, who);
      checks++; if (who !== want) begin errors++; $display("FAIL alt_grant[%0d] got %0d want %0d", n, who, want); end
      if (prev_acc >= 0) begin
        checks++; if (acc - prev_acc !== 4) begin errors++; $display("FAIL alt_spacing[%0d] got %0d want 4", n, acc - prev_acc); end
      end
      prev_acc = acc;
      sb.push_back('{id: (want == 1), data: (want == 1) ? &bus.req1_data : &bus.req0_data});
      get_rsp(acc, lat, d, id);
      e = sb.pop_front();
      checks++;
      if (d !== e.data || id !== e.id || lat !== 2) begin
        errors++; $display("FAIL alt_rsp[%0d] got d=%b id=%b lat=%0d want d=%b id=%b lat=2", n, d, id, lat, e.data, e.id);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_settle();
    logic [3:0] s_tab[4]   = '{4'd3, 4'd0, 4'd15, 4'd4};
    logic [3:0] d_tab[4]   = '{4'b1111, 4'b1111, 4'b0000, 4'b1111};
    int         lat_tab[4] = '{3, 1, 15, 4};
    int acc, who, lat;
    logic d, id;
    exp_t e;
    for (int n = 0; n < 4; n++) begin
      settle_cycles = s_tab[n];
      bus.req0_data = d_tab[n];
      bus.req0_valid = 1'b1;
      wait_accept(acc, who);
      bus.req0_valid = 1'b0;
      sb.push_back('{id: 1'b0, data: &d_tab[n]});
      if (n == 3) begin
        // reprogram mid-SETTLE; the in-flight latency must not move
        @(negedge clock);
        settle_cycles = 4'd1;
      end
      get_rsp(acc, lat, d, id);
      e = sb.pop_front();
      checks++; if (lat !== lat_tab[n]) begin errors++; $display("FAIL settle_latency[%0d] got %0d want %0d", n, lat, lat_tab[n]); end
      checks++; if (d !== e.data || id !== e.id) begin errors++; $display("FAIL settle_rsp[%0d] got d=%b id=%b want d=%b id=%b", n, d, id, e.data, e.id); end
    end
  endtask

  task automatic test_backpressure();
    int acc, who;
    logic seen;
    exp_t e;
    settle_cycles = 4'd2;
    bus.req1_data = 4'b1110;
    bus.req1_valid = 1'b1;
    wait_accept(acc, who);
    bus.req1_valid = 1'b0;
    sb.push_back('{id: 1'b1, data: 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_rsp_seen got %b want 1", seen); end
    bus.req0_data = 4'b0101;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req0_ready, bus.req1_ready, bus.net_in} !== 9'b1_0_1_0_0_1110) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%b id=%b rdy=%b%b net=%b want v=1 d=0 id=1 rdy=00 net=1110",
                 i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req1_ready, bus.req0_ready, bus.net_in);
      end
    end
    bus.req0_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (bus.rsp_data !== e.data || bus.rsp_id !== e.id) begin errors++; $display("FAIL bp_rsp got d=%b id=%b want d=%b id=%b", bus.rsp_data, bus.rsp_id, e.data, e.id); end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clock);
    checks++; if ({bus.rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release got v=%b busy=%b want 00", bus.rsp_valid, busy); end
  endtask

  task automatic test_short_settle();
    int acc, who, lat;
    logic d, id;
    exp_t e;
    half = 2.5;
    @(posedge clock); #1;
    settle_cycles = 4'd4;
    bus.req0_data = 4'b1111;
    bus.req0_valid = 1'b1;
    wait_accept(acc, who);
    bus.req0_valid = 1'b0;
    sb.push_back('{id: 1'b0, data: 1'b1});
    get_rsp(acc, lat, d, id);
    e = sb.pop_front();
    checks++; if (lat !== 4 || d !== e.data || id !== e.id) begin errors++; $display("FAIL short_prime got d=%b id=%b lat=%0d want d=%b id=%b lat=4", d, id, lat, e.data, e.id); end
    // 1110 needs 11 units to reach the output; one 5-unit cycle sees the old 1
    settle_cycles = 4'd1;
    bus.req0_data = 4'b1110;
    bus.req0_valid = 1'b1;
    wait_accept(acc, who);
    bus.req0_valid = 1'b0;
    sb.push_back('{id: 1'b0, data: 1'b1});
    get_rsp(acc, lat, d, id);
    e = sb.pop_front();
    checks++; if (lat !== 1 || d !== e.data || id !== e.id) begin errors++; $display("FAIL short_stale got d=%b id=%b lat=%0d want d=%b id=%b lat=1", d, id, lat, e.data, e.id); end
    half = 5.0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int acc, who, lat;
    logic d, id;
    exp_t e;
    settle_cycles = 4'd10;
    bus.req0_data = 4'b1111;
    bus.req0_valid = 1'b1;
    wait_accept(acc, who);
    bus.req0_valid = 1'b0;
    sb.push_back('{id: 1'b0, data: 1'b1});
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.net_in, bus.rsp_valid, bus.rsp_data, bus.rsp_id, busy} !== 8'b0) begin
      errors++; $display("FAIL rmid_outputs got net=%b v=%b d=%b id=%b busy=%b want all 0", bus.net_in, bus.rsp_valid, bus.rsp_data, bus.rsp_id, busy);
    end
    sb.delete();
    exp_ptr = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    settle_cycles = 4'd2;
    bus.req0_data = 4'b0111;
    bus.req1_data = 4'b1111;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    wait_accept(acc, who);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checks++; if (who !== 0) begin errors++; $display("FAIL rmid_first_grant got %0d want 0", who); end
    sb.push_back('{id: 1'b0, data: 1'b0});
    get_rsp(acc, lat, d, id);
    e = sb.pop_front();
    checks++; if (lat !== 2 || d !== e.data || id !== e.id) begin errors++; $display("FAIL rmid_rsp got d=%b id=%b lat=%0d want d=%b id=%b lat=2", d, id, lat, e.data, e.id); end
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_data  = 4'b0000;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 4'b0000;
    bus.rsp_ready  = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_settle();
    test_backpressure();
    test_short_settle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/settle_sequencer.md
Name: settle_sequencer

Overview:
Controller that shares one combinational 4-input AND network (distributed gate delays, worst-case path 11 time units) between two requesters. It arbitrates round-robin and launches the winning operand onto the network's inputs. It then waits a programmable number of clock cycles for the network to settle, samples the output, and returns the result with a valid/ready handshake. It sits between the stimulus/requester logic and the delay network.

Parameters:
CNT_W, 4, width of the settle counter and of settle_cycles (max settle = 2^CNT_W-1 cycles)
DATA_W, 4, operand width driven onto the network (one bit per network input a,b,c,d; MSB = a)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
settle_cycles  input  CNT_W  settle wait in cycles, sampled at accept
req0_valid  input  1  requester 0 has an operand
req0_data  input  DATA_W  requester 0 operand
req0_ready  output  1  requester 0 operand accepted this cycle
req1_valid  input  1  requester 1 has an operand
req1_data  input  DATA_W  requester 1 operand
req1_ready  output  1  requester 1 operand accepted this cycle
net_in  output  DATA_W  registered drive to network inputs {a,b,c,d}
net_out  input  1  network output
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_data  output  1  sampled network output
rsp_id  output  1  requester that owns rsp_data
busy  output  1  high in any state other than IDLE

Behaviour:
- Async reset (reset_n low): state=IDLE, net_in=0, rsp_valid=0, rsp_data=0, rsp_id=0, counter=0, rr pointer=0 (requester 0 has priority first). Reset mid-operation aborts the transaction; the result is discarded.
- States: IDLE -> SETTLE -> RESP -> IDLE.
- IDLE: grant computed combinationally from the valids and the rr pointer. If only one requester is valid, it wins. If both are valid, the pointer holder wins. reqN_ready = (state==IDLE) && grant==N; at most one ready is high per cycle. Ready is 0 in every other state.
- Accept edge (valid&&ready): net_in<=reqN_data, rsp_id<=N, counter<=eff_settle, rr pointer<=~N, state<=SETTLE.
- eff_settle = settle_cycles, except settle_cycles==0, which is treated as 1. Changes to settle_cycles after accept have no effect on the transaction in flight.
- SETTLE: counter decrements each edge. On the edge where counter==1, rsp_data<=net_out, rsp_valid<=1, state<=RESP.
- Latency: with accept at edge T and settle value S, rsp_valid rises at edge T+S. net_out is sampled S full cycles after net_in changed.
- net_in is held stable from accept until the next accept, including through RESP and IDLE; it never glitches between transactions.
- RESP: rsp_valid, rsp_data and rsp_id are held stable until rsp_ready. On the edge with rsp_ready: rsp_valid<=0, state<=IDLE. No new accept occurs on that same edge. The earliest next accept is the following edge, giving throughput of 1 result per S+2 cycles.
- rsp_ready high while rsp_valid is low is ignored. Requester valids while busy are ignored; requesters hold valid/data until ready.
- Counter never wraps: the load value is 1..2^CNT_W-1, and decrement happens only in SETTLE.

Decomposition:
- Package settle_seq_pkg: state encoding constants (IDLE=2'd0, SETTLE=2'd1, RESP=2'd2), DATA_W/CNT_W defaults, requester ID width.
- Sub-module rr_arbiter_2: two-requester round-robin grant. Inputs: valids, pointer, enable. Outputs: one-hot grant and grant index.
- The FSM, counter and net_in register stay in the top module.

Test Plan:
- Single request: req0_data=4'b1111, settle_cycles=2 (10-unit clock, network worst path 11 units) -> net_in=1111 after accept, rsp_valid at accept+2, rsp_data=1, rsp_id=0.
- Both requesters valid each cycle: req0=4'b0111, req1=4'b1111 -> grants alternate 0,1,0,1. Responses are rsp_data=0 (id 0) and rsp_data=1 (id 1). No two consecutive grants go to the same requester.
- settle_cycles=0 -> behaves exactly as 1; settle_cycles=15 -> rsp_valid exactly 15 cycles after accept. Changing settle_cycles during SETTLE does not change the latency.
- Backpressure: rsp_ready held low for 6 cycles -> rsp_valid, rsp_data and rsp_id stay stable; no reqN_ready is asserted; net_in is unchanged.
- Too-short settle: settle_cycles=1 with a 5-unit clock, transition 1111->1110 -> stale rsp_data=1 captured. This documents that settle programming is the requester's responsibility.
- reset_n pulsed low during SETTLE -> outputs immediately return to reset values and the rr pointer is 0. After release, the first grant goes to requester 0 when both are valid.
